// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : des_pkg
//  Purpose  : Shared DES substitution definitions: FSM state encoding, the
//             6-bit input to (row, column) split and the eight S-box tables.
//  Revision : 1.0  initial release
// ============================================================================
package des_pkg;

    // Control states of the substitution unit
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } des_state_e;

    // Table address derived from a 6-bit S-box input
    typedef struct packed {
        logic [1:0] row;
        logic [3:0] col;
    } sbox_addr_t;

    // One 64-bit word per table row; column 0 is the most significant nibble.
    // Entry index is {sbox[2:0], row[1:0]}.
    localparam logic [63:0] SBOX_ROWS [32] = '{
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
    };

    // Outer bits select the row, inner four bits select the column
    function automatic sbox_addr_t sbox_split(input logic [5:0] b);
        sbox_addr_t a;
        a.row = {b[5], b[0]};
        a.col = b[4:1];
        return a;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sbox_lookup.sv
`default_nettype none
// ============================================================================
//  Module   : sbox_lookup
//  Purpose  : Combinational single DES S-box lookup; the S-box is selected
//             at run time so one instance can serve several tables.
//  Revision : 1.0  initial release
// ============================================================================
module sbox_lookup
    import des_pkg::*;
(
    input  logic [2:0] sbox_idx_i,
    input  logic [5:0] value_i,
    output logic [3:0] nibble_o
);

    sbox_addr_t  w_addr;
    logic [63:0] w_row_word;

    // Select the table row word, then pick the column nibble out of it
    always_comb begin
        w_addr     = sbox_split(value_i);
        w_row_word = SBOX_ROWS[{sbox_idx_i, w_addr.row}];
        nibble_o   = w_row_word[63 - 4*int'(w_addr.col) -: 4];
    end

endmodule
`default_nettype wire

// File: rtl/sbox_subst_unit.sv
`default_nettype none
// ============================================================================
//  Module   : sbox_subst_unit
//  Purpose  : DES S-box substitution of a 48-bit expanded half-block into a
//             32-bit result, LANES lookups per cycle over 8/LANES cycles,
//             with valid/ready handshakes on both sides.
//  Revision : 1.0  initial release
// ============================================================================
module sbox_subst_unit
    import des_pkg::*;
#(
    parameter int LANES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    localparam int STEPS  = 8 / LANES;
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

    des_state_e        state_q, state_d;
    logic [STEP_W-1:0] step_q,  step_d;
    logic [47:0]       data_q,  data_d;
    logic [31:0]       result_q, result_d;
    logic              w_accept;

    logic [2:0] w_lane_idx [LANES];
    logic [5:0] w_lane_val [LANES];
    logic [3:0] w_lane_nib [LANES];

    // Lane l serves S-box step*LANES+l; only the step counter steers the mux
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_lane_idx[l] = 3'(int'(step_q) * LANES + l);
        assign w_lane_val[l] = data_q[47 - 6*int'(w_lane_idx[l]) -: 6];

        sbox_lookup u_lookup (
            .sbox_idx_i (w_lane_idx[l]),
            .value_i    (w_lane_val[l]),
            .nibble_o   (w_lane_nib[l])
        );
    end

    // Handshake and status outputs decoded from the current state
    always_comb begin
        in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
        w_accept  = in_valid && in_ready;
        out_valid = (state_q == ST_DONE);
        busy      = (state_q != ST_IDLE);
        out_data  = result_q;
    end

    // Next-state logic: accept, step through the lanes, hold result in DONE
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        data_d   = data_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    data_d   = in_data;
                    step_d   = '0;
                    result_d = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int l = 0; l < LANES; l++) begin
                    result_d[31 - 4*int'(w_lane_idx[l]) -: 4] = w_lane_nib[l];
                end
                if (step_q == LAST_STEP) begin
                    step_d  = '0;
                    state_d = ST_DONE;
                end else begin
                    step_d  = step_q + STEP_W'(1);
                end
            end
            ST_DONE: begin
                // Output handshake and a new accept may share one edge
                if (w_accept) begin
                    data_d   = in_data;
                    step_d   = '0;
                    result_d = '0;
                    state_d  = ST_RUN;
                end else if (out_ready) begin
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset discards any in-flight block
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            step_q   <= '0;
            data_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            data_q   <= data_d;
            result_q <= result_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sbox_subst_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sbox_subst_unit
//  Purpose  : Self-checking bench for sbox_subst_unit; one instance for each
//             legal LANES value (1, 2, 4, 8), exercised one at a time.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sbox_subst_unit;

    // Independent copy of the DES tables: one row per word, column 0 first
    localparam logic [63:0] TAB [32] = '{
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
    };

    logic        clk;
    logic        rst;
    logic        iv  [4];
    logic        ir  [4];
    logic        ov  [4];
    logic        orr [4];
    logic        bsy [4];
    logic [47:0] id  [4];
    logic [31:0] od  [4];

    int          n_checks;
    int          n_errors;
    logic [31:0] sb [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sbox_subst_unit #(.LANES(1 << g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .in_data   (id[g]),
            .out_valid (ov[g]),
            .out_ready (orr[g]),
            .out_data  (od[g]),
            .busy      (bsy[g])
        );
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation time limit");
    end

    function automatic logic [31:0] ref_sub(input logic [47:0] x);
        logic [31:0] r;
        logic [5:0]  b;
        logic [63:0] w;
        int          row;
        int          col;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            b   = x[47 - 6*k -: 6];
            row = 2*int'(b[5]) + int'(b[0]);
            col = int'(b[4:1]);
            w   = TAB[4*k + row] >> (4*(15 - col));
            r   = (r << 4) | 32'(w & 64'hF);
        end
        return r;
    endfunction

    function automatic logic [47:0] rnd48();
        return {16'($urandom), $urandom};
    endfunction

    function automatic string tg(input string s, input int d);
        return $sformatf("%s_L%0d", s, 1 << d);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare out_data against the oldest scoreboard entry
    task automatic pop_check(input int d, input string tag);
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL %s: observed=empty_scoreboard expected=entry", tag);
        end else begin
            chk(tag, od[d], sb.pop_front());
        end
    endtask

    // Present one block and take the accepting edge; ends in the first RUN cycle
    task automatic accept_block(input int d, input logic [47:0] data,
                                input logic [31:0] exp, input bit push);
        #1;
        chk(tg("acc_ready", d), 32'(ir[d]), 32'd1);
        iv[d] = 1'b1;
        id[d] = data;
        if (push) sb.push_back(exp);
        tick();
        iv[d]  = 1'b0;
        orr[d] = 1'b0;
        id[d]  = rnd48();
        chk(tg("run_clear", d), od[d], 32'h0);
        chk(tg("run_flags", d), 32'({ov[d], ir[d], bsy[d]}), 32'b001);
    endtask

    task automatic await_valid(input int d, input int n);
        int k;
        k = 0;
        while (ov[d] !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        chk(tg("latency", d), 32'(k), 32'(n));
    endtask

    // Accept a block and run it to DONE, checking partial results on the way
    task automatic run_to_done(input int d, input logic [47:0] data, input logic [31:0] exp);
        int          steps;
        logic [31:0] mask;
        steps = 8 >> d;
        accept_block(d, data, exp, 1'b1);
        if (steps > 1) begin
            mask = 32'hFFFF_FFFF;
            mask = ~(mask >> (4 * (1 << d)));
            tick();
            chk(tg("partial", d), od[d], exp & mask);
            await_valid(d, steps - 1);
        end else begin
            await_valid(d, 1);
        end
    endtask

    // Complete the output handshake with no new input; unit returns to IDLE
    task automatic release_out(input int d);
        iv[d]  = 1'b0;
        orr[d] = 1'b1;
        pop_check(d, tg("out_data", d));
        tick();
        orr[d] = 1'b0;
        chk(tg("post_flags", d), 32'({ov[d], ir[d], bsy[d]}), 32'b010);
    endtask

    initial begin
        logic [47:0] data;
        logic [31:0] exp;
        int          seen;

        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        for (int d = 0; d < 4; d++) begin
            iv[d]  = 1'b0;
            orr[d] = 1'b0;
            id[d]  = '0;
        end

        // Reset state
        tick();
        tick();
        for (int d = 0; d < 4; d++) begin
            chk(tg("rst_flags", d), 32'({ov[d], ir[d], bsy[d]}), 32'b010);
            chk(tg("rst_data", d), od[d], 32'h0);
        end
        rst = 1'b0;

        // Known vectors: all-zero with 8 lanes, all-ones with 2 lanes
        run_to_done(3, 48'h0, 32'hEFA72C4D);
        release_out(3);
        run_to_done(1, 48'hFFFF_FFFF_FFFF, 32'hD9CE3DCB);
        release_out(1);

        // Random blocks on every lane count
        for (int d = 0; d < 4; d++) begin
            for (int i = 0; i < 3; i++) begin
                data = rnd48();
                run_to_done(d, data, ref_sub(data));
                release_out(d);
            end
        end

        // One lane: output held while out_ready stays low; new input is refused
        data = rnd48();
        exp  = ref_sub(data);
        run_to_done(0, data, exp);
        for (int i = 0; i < 10; i++) begin
            iv[0] = 1'b1;
            id[0] = rnd48();
            #1;
            chk("hold_data_L1", od[0], exp);
            chk("hold_flags_L1", 32'({ov[0], ir[0], bsy[0]}), 32'b101);
            tick();
        end
        release_out(0);

        // Four lanes: DONE handshake and new accept on the same edge
        data = rnd48();
        run_to_done(2, data, ref_sub(data));
        orr[2] = 1'b1;
        pop_check(2, "b2b_first_L4");
        accept_block(2, 48'h0, 32'hEFA72C4D, 1'b1);
        tick();
        chk("b2b_partial_L4", od[2], 32'hEFA70000);
        await_valid(2, 1);
        release_out(2);

        // Reset on the second RUN cycle (or in DONE for 8 lanes) drops the block
        for (int d = 0; d < 4; d++) begin
            if (d < 3) begin
                accept_block(d, rnd48(), 32'h0, 1'b0);
                tick();
            end else begin
                data = rnd48();
                run_to_done(d, data, ref_sub(data));
                sb.delete();
            end
            rst    = 1'b1;
            iv[d]  = 1'b1;
            orr[d] = 1'b1;
            tick();
            rst    = 1'b0;
            iv[d]  = 1'b0;
            orr[d] = 1'b0;
            chk(tg("abort_flags", d), 32'({ov[d], ir[d], bsy[d]}), 32'b010);
            chk(tg("abort_data", d), od[d], 32'h0);
            seen = 0;
            for (int i = 0; i < 12; i++) begin
                if (ov[d] === 1'b1) seen++;
                tick();
            end
            chk(tg("abort_no_valid", d), 32'(seen), 32'd0);
        end

        // Exhaustive per-S-box sweep with the other fields at zero
        for (int d = 0; d < 4; d++) begin
            for (int k = 0; k < 8; k++) begin
                for (int v = 0; v < 64; v++) begin
                    data = 48'(v) << (42 - 6*k);
                    run_to_done(d, data, ref_sub(data));
                    release_out(d);
                end
            end
        end

        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
